// File: rtl/switch_conditioner.sv
// ---------------------------------------------------------------------------
// switch_conditioner
//
// Input-side conditioner for the watch. The raw slide-switch bus arrives
// asynchronously to mclk. Each bit is passed through a 2-flop synchronizer,
// debounced by a per-bit counter and edge-detected, so the watch core sees
// clean option levels and single-cycle change pulses.
//
// Parameters
//   WIDTH      number of switch bits conditioned
//   DB_CYCLES  consecutive mclk cycles a new level must hold before it is
//              accepted (legal range >= 2)
//
// Ports
//   mclk        in   1      system clock
//   rst_n       in   1      asynchronous reset, active low
//   sw_raw      in   WIDTH  raw switch levels, asynchronous to mclk
//   sw_stable   out  WIDTH  debounced switch levels (registered)
//   sw_rise     out  WIDTH  1-cycle pulse per bit on an accepted 0->1 change
//   sw_fall     out  WIDTH  1-cycle pulse per bit on an accepted 1->0 change
//   sw_changed  out  1      1-cycle pulse, OR of all accepted changes
//   settled     out  1      1 when no bit has a debounce count in progress
//
// Build option
//   SWCOND_EDGE_EN  when defined, the edge pulse registers are built. When
//                   undefined, sw_rise, sw_fall and sw_changed are tied to 0;
//                   sw_stable and settled behave identically in both builds.
// ---------------------------------------------------------------------------
module switch_conditioner #(
  parameter int WIDTH     = 10,
  parameter int DB_CYCLES = 500000
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  output logic             settled
);

  // DB_CYCLES-1 always fits in $clog2(DB_CYCLES) bits, so the counter
  // saturates at CNT_MAX and never wraps.
  localparam int             CW      = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             busy_s;

  // Two-flop synchronizer; only the second stage feeds the debouncer.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: count while s2 differs from the accepted level,
  // accept on the DB_CYCLES-th consecutive differing cycle.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debounce counters and accepted levels.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Any non-zero counter means a bit is still being debounced.
  always_comb begin
    busy_s = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      busy_s = busy_s | (|cnt_q[i]);
    end
  end

  assign sw_stable = stable_q;
  assign settled   = ~busy_s;

`ifdef SWCOND_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic             changed_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic             changed_d;

  // Edges are taken from the same next-state that updates stable_q, so a
  // pulse lines up with the first cycle sw_stable shows the new level.
  always_comb begin
    rise_d    = stable_d & ~stable_q;
    fall_d    = ~stable_d & stable_q;
    changed_d = |(stable_d ^ stable_q);
  end

  // Edge pulse registers.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign sw_changed = changed_q;
`else
  assign sw_rise    = '0;
  assign sw_fall    = '0;
  assign sw_changed = 1'b0;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// ---------------------------------------------------------------------------
// tb_switch_conditioner
//
// Directed bench for switch_conditioner with WIDTH=10, DB_CYCLES=4.
// Each stimulus step drives rst_n/sw_raw on the falling clock edge and queues
// the hand-derived output state expected after the following rising edge.
// An independent monitor pops entries due on each rising edge (sampled 1
// time unit later) and compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_switch_conditioner;

  logic       mclk;
  logic       rst_n;
  logic [9:0] sw_raw;
  logic [9:0] sw_stable;
  logic [9:0] sw_rise;
  logic [9:0] sw_fall;
  logic       sw_changed;
  logic       settled;

  typedef struct {
    int         due;
    logic [9:0] stable;
    logic [9:0] rise;
    logic [9:0] fall;
    logic       changed;
    logic       settled;
  } exp_t;

  exp_t sb_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  switch_conditioner #(
    .WIDTH    (10),
    .DB_CYCLES(4)
  ) dut (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed),
    .settled   (settled)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: compare every queued expectation on the cycle it falls due.
  always @(posedge mclk) begin
    exp_t e;
    #1;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      if (e.due != cyc) begin
        failures++;
        $display("FAIL sb_missed due=%0d actual_cyc=%0d required_cyc=%0d", e.due, cyc, e.due);
      end
      check("sw_stable",  sw_stable,          e.stable);
      check("sw_rise",    sw_rise,            e.rise);
      check("sw_fall",    sw_fall,            e.fall);
      check("sw_changed", {9'd0, sw_changed}, {9'd0, e.changed});
      check("settled",    {9'd0, settled},    {9'd0, e.settled});
    end
  end

  // Drive one cycle of stimulus and queue the state expected after the
  // next rising edge. Edge pulses are absent in the build without them.
  task automatic step(input logic rn, input logic [9:0] raw, input logic [9:0] st,
                      input logic [9:0] ri, input logic [9:0] fa, input logic se);
    exp_t e;
    @(negedge mclk);
    rst_n  = rn;
    sw_raw = raw;
    e.due     = cyc + 1;
    e.stable  = st;
`ifdef SWCOND_EDGE_EN
    e.rise    = ri;
    e.fall    = fa;
    e.changed = |(ri | fa);
`else
    e.rise    = 10'h000;
    e.fall    = 10'h000;
    e.changed = 1'b0;
`endif
    e.settled = se;
    sb_q.push_back(e);
  endtask

  initial begin
    logic [0:15] b3_pat;
    logic [0:15] se_pat;
    logic [9:0]  raw3;
    logic [9:0]  st3;
    logic [9:0]  ri3;
    int          wait_cnt;

    rst_n  = 1'b0;
    sw_raw = 10'h3FF;

    // Test 1: all switches high through reset, then release.
    repeat (3) step(1'b0, 10'h3FF, 10'h000, 10'h000, 10'h000, 1'b1);
    repeat (2) step(1'b1, 10'h3FF, 10'h000, 10'h000, 10'h000, 1'b1);
    repeat (3) step(1'b1, 10'h3FF, 10'h000, 10'h000, 10'h000, 1'b0);
    step(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 10'h000, 1'b1);
    step(1'b1, 10'h3FF, 10'h3FF, 10'h000, 10'h000, 1'b1);

    // All switches back low: one fall pulse on every bit.
    repeat (2) step(1'b1, 10'h000, 10'h3FF, 10'h000, 10'h000, 1'b1);
    repeat (3) step(1'b1, 10'h000, 10'h3FF, 10'h000, 10'h000, 1'b0);
    step(1'b1, 10'h000, 10'h000, 10'h000, 10'h3FF, 1'b1);
    step(1'b1, 10'h000, 10'h000, 10'h000, 10'h000, 1'b1);

    // Test 2: 3-cycle glitch on bit0 is one cycle too short to be accepted.
    repeat (2) step(1'b1, 10'h001, 10'h000, 10'h000, 10'h000, 1'b1);
    step(1'b1, 10'h001, 10'h000, 10'h000, 10'h000, 1'b0);
    repeat (2) step(1'b1, 10'h000, 10'h000, 10'h000, 10'h000, 1'b0);
    repeat (2) step(1'b1, 10'h000, 10'h000, 10'h000, 10'h000, 1'b1);

    // Test 3: bit3 bounces every 2 cycles, last edge at step 8, then holds.
    b3_pat = 16'b1100110011111111;
    se_pat = 16'b1100110011000111;
    for (int j = 0; j < 16; j++) begin
      raw3 = {6'd0, b3_pat[j], 3'd0};
      st3  = (j >= 13) ? 10'h008 : 10'h000;
      ri3  = (j == 13) ? 10'h008 : 10'h000;
      step(1'b1, raw3, st3, ri3, 10'h000, se_pat[j]);
    end

    // Simultaneous bit9 rise and bit3 fall: one sw_changed pulse.
    repeat (2) step(1'b1, 10'h200, 10'h008, 10'h000, 10'h000, 1'b1);
    repeat (3) step(1'b1, 10'h200, 10'h008, 10'h000, 10'h000, 1'b0);
    step(1'b1, 10'h200, 10'h200, 10'h200, 10'h008, 1'b1);
    step(1'b1, 10'h200, 10'h200, 10'h000, 10'h000, 1'b1);

    // Test 4: stable 10'h200, bit9 drops.
    repeat (2) step(1'b1, 10'h000, 10'h200, 10'h000, 10'h000, 1'b1);
    repeat (3) step(1'b1, 10'h000, 10'h200, 10'h000, 10'h000, 1'b0);
    step(1'b1, 10'h000, 10'h000, 10'h000, 10'h200, 1'b1);
    step(1'b1, 10'h000, 10'h000, 10'h000, 10'h000, 1'b1);

    // Test 5: bit5 high, reset asserted with its count at 2, then released.
    repeat (2) step(1'b1, 10'h020, 10'h000, 10'h000, 10'h000, 1'b1);
    repeat (2) step(1'b1, 10'h020, 10'h000, 10'h000, 10'h000, 1'b0);
    repeat (2) step(1'b0, 10'h020, 10'h000, 10'h000, 10'h000, 1'b1);
    repeat (2) step(1'b1, 10'h020, 10'h000, 10'h000, 10'h000, 1'b1);
    repeat (3) step(1'b1, 10'h020, 10'h000, 10'h000, 10'h000, 1'b0);
    step(1'b1, 10'h020, 10'h020, 10'h020, 10'h000, 1'b1);
    step(1'b1, 10'h020, 10'h020, 10'h000, 10'h000, 1'b1);

    // Drain the scoreboard within a bounded number of cycles.
    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 20) begin
      @(posedge mclk);
      #2;
      wait_cnt++;
    end
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL sb_drain actual_pending=%0d required_pending=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
